// File: rtl/barrel_shift_pipe.sv
// Pipelined four-mode barrel shifter (SLL/SRL/SRA/ROR), one log2 stage per register, valid/ready on both sides.
// Define BSHIFT_FLAGS_EN to add the registered out_zero / out_carry flag outputs.
module barrel_shift_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef BSHIFT_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_carry
`endif
);

  typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_ROR = 2'b11} op_e;

  logic w_advance;

  function automatic logic [WIDTH-1:0] shiftBy(input logic [WIDTH-1:0] v, input int s,
                                               input logic [1:0] op, input logic sgn);
    logic [WIDTH-1:0] fill;
    fill = {WIDTH{sgn}} << (WIDTH - s);
    case (op)
      OP_SLL:  shiftBy = v << s;
      OP_SRL:  shiftBy = v >> s;
      OP_SRA:  shiftBy = (v >> s) | fill;
      default: shiftBy = (v >> s) | (v << (WIDTH - s));
    endcase
  endfunction

`ifdef BSHIFT_FLAGS_EN
  // Bit that leaves the word last when shifting v by s in the given mode.
  function automatic logic shiftOut(input logic [WIDTH-1:0] v, input int s, input logic [1:0] op);
    logic [WIDTH-1:0] t;
    t = (op == OP_SLL) ? (v >> (WIDTH - s)) : (v >> (s - 1));
    shiftOut = t[0];
  endfunction
`endif

  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;

  for (genvar g = 0; g < SHW; g++) begin : gStage
    localparam int S = 1 << g;

    logic [WIDTH-1:0] w_data;
    logic             w_valid;
    logic [SHW-1:g]   w_amt;
    logic [1:0]       w_op;
    logic             w_sign;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
`ifdef BSHIFT_FLAGS_EN
    logic             w_carry;
    logic             r_carry;
`endif

    if (g == 0) begin : gIn
      assign w_data  = in_data;
      assign w_valid = in_valid;
      assign w_amt   = in_amt;
      assign w_op    = in_op;
      assign w_sign  = in_data[WIDTH-1];
`ifdef BSHIFT_FLAGS_EN
      assign w_carry = 1'b0;
`endif
    end else begin : gChain
      assign w_data  = gStage[g-1].r_data;
      assign w_valid = gStage[g-1].r_valid;
      assign w_amt   = gStage[g-1].gMeta.r_amt;
      assign w_op    = gStage[g-1].gMeta.r_op;
      assign w_sign  = gStage[g-1].gMeta.r_sign;
`ifdef BSHIFT_FLAGS_EN
      assign w_carry = gStage[g-1].r_carry;
`endif
    end

    assign w_result = w_amt[g] ? shiftBy(w_data, S, w_op, w_sign) : w_data;

    // Whole pipe moves together; a stalled output freezes every stage.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_data  <= '0;
        r_valid <= 1'b0;
      end else if (w_advance) begin
        r_data  <= w_result;
        r_valid <= w_valid;
      end
    end

`ifdef BSHIFT_FLAGS_EN
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_carry <= 1'b0;
      end else if (w_advance) begin
        r_carry <= w_amt[g] ? shiftOut(w_data, S, w_op) : w_carry;
      end
    end
`endif

    // Control only needs to ride along while a later stage still consumes it.
    if (g < SHW - 1) begin : gMeta
      logic [SHW-1:g+1] r_amt;
      logic [1:0]       r_op;
      logic             r_sign;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_amt  <= '0;
          r_op   <= 2'b00;
          r_sign <= 1'b0;
        end else if (w_advance) begin
          r_amt  <= w_amt[SHW-1:g+1];
          r_op   <= w_op;
          r_sign <= w_sign;
        end
      end
    end
  end

  assign out_data  = gStage[SHW-1].r_data;
  assign out_valid = gStage[SHW-1].r_valid;

`ifdef BSHIFT_FLAGS_EN
  logic r_zero;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_zero <= 1'b0;
    end else if (w_advance) begin
      r_zero <= (gStage[SHW-1].w_result == '0);
    end
  end

  assign out_zero  = r_zero;
  assign out_carry = gStage[SHW-1].r_carry;
`endif

endmodule
